mem_wb_reg: RTL and testbench



---
 rtl/mem_wb_reg.sv | 115 +++++++++++
 tb/tb_mem_wb_reg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: one-cycle capture of MEM results and control,
// with hazard-unit stall (hold) and flush (bubble).
module mem_wb_reg #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          valid,
  input  logic [DW-1:0] npc,
  input  logic [DW-1:0] rs_data,
  input  logic [2:0]    rd_sel,
  input  logic [AW-1:0] rd_waddr,
  input  logic          rd_wena,
  input  logic [DW-1:0] hi_data,
  input  logic [DW-1:0] lo_data,
  input  logic          hi_wena,
  input  logic          lo_wena,
  input  logic [1:0]    hi_sel,
  input  logic [1:0]    lo_sel,
  input  logic [DW-1:0] cp0_data,
  input  logic [DW-1:0] alu_data,
  input  logic [DW-1:0] clz_data,
  input  logic [DW-1:0] mul_hi,
  input  logic [DW-1:0] mul_lo,
  input  logic [DW-1:0] div_r,
  input  logic [DW-1:0] div_q,
  input  logic [DW-1:0] dmem_data,
  output logic          valid_out,
  output logic [DW-1:0] npc_out,
  output logic [DW-1:0] rs_data_out,
  output logic [2:0]    rd_sel_out,
  output logic [AW-1:0] rd_waddr_out,
  output logic          rd_wena_out,
  output logic [DW-1:0] hi_data_out,
  output logic [DW-1:0] lo_data_out,
  output logic          hi_wena_out,
  output logic          lo_wena_out,
  output logic [1:0]    hi_sel_out,
  output logic [1:0]    lo_sel_out,
  output logic [DW-1:0] cp0_data_out,
  output logic [DW-1:0] alu_data_out,
  output logic [DW-1:0] clz_data_out,
  output logic [DW-1:0] mul_hi_out,
  output logic [DW-1:0] mul_lo_out,
  output logic [DW-1:0] div_r_out,
  output logic [DW-1:0] div_q_out,
  output logic [DW-1:0] dmem_data_out
);

  logic capture;
  assign capture = !flush && !stall;

  // Control: flush clears, stall holds, else qualify enables with valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out   <= 1'b0;
      rd_wena_out <= 1'b0;
      hi_wena_out <= 1'b0;
      lo_wena_out <= 1'b0;
    end else if (flush) begin
      valid_out   <= 1'b0;
      rd_wena_out <= 1'b0;
      hi_wena_out <= 1'b0;
      lo_wena_out <= 1'b0;
    end else if (!stall) begin
      valid_out   <= valid;
      rd_wena_out <= rd_wena & valid & (rd_waddr != '0);
      hi_wena_out <= hi_wena & valid;
      lo_wena_out <= lo_wena & valid;
    end
  end

  // Data fields simply hold across flush; only the enables matter there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      npc_out       <= '0;
      rs_data_out   <= '0;
      rd_sel_out    <= '0;
      rd_waddr_out  <= '0;
      hi_data_out   <= '0;
      lo_data_out   <= '0;
      hi_sel_out    <= '0;
      lo_sel_out    <= '0;
      cp0_data_out  <= '0;
      alu_data_out  <= '0;
      clz_data_out  <= '0;
      mul_hi_out    <= '0;
      mul_lo_out    <= '0;
      div_r_out     <= '0;
      div_q_out     <= '0;
      dmem_data_out <= '0;
    end else if (capture) begin
      npc_out       <= npc;
      rs_data_out   <= rs_data;
      rd_sel_out    <= rd_sel;
      rd_waddr_out  <= rd_waddr;
      hi_data_out   <= hi_data;
      lo_data_out   <= lo_data;
      hi_sel_out    <= hi_sel;
      lo_sel_out    <= lo_sel;
      cp0_data_out  <= cp0_data;
      alu_data_out  <= alu_data;
      clz_data_out  <= clz_data;
      mul_hi_out    <= mul_hi;
      mul_lo_out    <= mul_lo;
      div_r_out     <= div_r;
      div_q_out     <= div_q;
      dmem_data_out <= dmem_data;
    end
  end

endmodule

// File: tb/tb_mem_wb_reg.sv
// Randomized bench for mem_wb_reg against a field-level behavioural model,
// plus directed scenarios with literal expectations.
module tb_mem_wb_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] npc;
    logic [31:0] rs_data;
    logic [2:0]  rd_sel;
    logic [4:0]  rd_waddr;
    logic        rd_wena;
    logic [31:0] hi_data;
    logic [31:0] lo_data;
    logic        hi_wena;
    logic        lo_wena;
    logic [1:0]  hi_sel;
    logic [1:0]  lo_sel;
    logic [31:0] cp0_data;
    logic [31:0] alu_data;
    logic [31:0] clz_data;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic [31:0] div_r;
    logic [31:0] div_q;
    logic [31:0] dmem_data;
  } fields_t;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    stall = 1'b0;
  logic    flush = 1'b0;
  fields_t in = '0;
  fields_t out;
  fields_t exp_q = '0;
  logic    data_known = 1'b1;
  int      checks = 0;
  int      errors = 0;

  always #5 clk = ~clk;

  mem_wb_reg #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .valid(in.valid), .npc(in.npc), .rs_data(in.rs_data),
    .rd_sel(in.rd_sel), .rd_waddr(in.rd_waddr), .rd_wena(in.rd_wena),
    .hi_data(in.hi_data), .lo_data(in.lo_data),
    .hi_wena(in.hi_wena), .lo_wena(in.lo_wena),
    .hi_sel(in.hi_sel), .lo_sel(in.lo_sel),
    .cp0_data(in.cp0_data), .alu_data(in.alu_data),
    .clz_data(in.clz_data), .mul_hi(in.mul_hi), .mul_lo(in.mul_lo),
    .div_r(in.div_r), .div_q(in.div_q), .dmem_data(in.dmem_data),
    .valid_out(out.valid), .npc_out(out.npc),
    .rs_data_out(out.rs_data), .rd_sel_out(out.rd_sel),
    .rd_waddr_out(out.rd_waddr), .rd_wena_out(out.rd_wena),
    .hi_data_out(out.hi_data), .lo_data_out(out.lo_data),
    .hi_wena_out(out.hi_wena), .lo_wena_out(out.lo_wena),
    .hi_sel_out(out.hi_sel), .lo_sel_out(out.lo_sel),
    .cp0_data_out(out.cp0_data), .alu_data_out(out.alu_data),
    .clz_data_out(out.clz_data), .mul_hi_out(out.mul_hi),
    .mul_lo_out(out.mul_lo), .div_r_out(out.div_r),
    .div_q_out(out.div_q), .dmem_data_out(out.dmem_data)
  );

  // Behavioural model: what WB must see after one edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q = '0;
      data_known = 1'b1;
    end else if (flush) begin
      exp_q.valid = 1'b0;
      exp_q.rd_wena = 1'b0;
      exp_q.hi_wena = 1'b0;
      exp_q.lo_wena = 1'b0;
      data_known = 1'b0;
    end else if (!stall) begin
      exp_q = in;
      exp_q.rd_wena = in.rd_wena && in.valid && (in.rd_waddr != 5'd0);
      exp_q.hi_wena = in.hi_wena && in.valid;
      exp_q.lo_wena = in.lo_wena && in.valid;
      data_known = 1'b1;
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    logic ok;
    ok = 1'b1;
    if ($isunknown(out)) ok = 1'b0;
    else if (data_known) ok = (out == exp_q);
    else ok = (out.valid == exp_q.valid) && (out.rd_wena == exp_q.rd_wena)
           && (out.hi_wena == exp_q.hi_wena) && (out.lo_wena == exp_q.lo_wena);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, out, exp_q);
    end
    checks++;
    if (!out.valid && (out.rd_wena || out.hi_wena || out.lo_wena)) begin
      errors++;
      $display("FAIL enable_invariant t=%0t got=%b%b%b%b exp=valid-gated",
               $time, out.valid, out.rd_wena, out.hi_wena, out.lo_wena);
    end
  end

  task automatic lit(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, want);
    end
  endtask

  function automatic fields_t rand_fields();
    fields_t f;
    f = '0;
    f.valid = ($urandom_range(0, 3) != 0);
    f.npc = $urandom();
    f.rs_data = $urandom();
    f.rd_sel = 3'($urandom_range(0, 7));
    f.rd_waddr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    f.rd_wena = 1'($urandom_range(0, 1));
    f.hi_data = $urandom();
    f.lo_data = $urandom();
    f.hi_wena = 1'($urandom_range(0, 1));
    f.lo_wena = 1'($urandom_range(0, 1));
    f.hi_sel = 2'($urandom_range(0, 3));
    f.lo_sel = 2'($urandom_range(0, 3));
    f.cp0_data = $urandom();
    f.alu_data = $urandom();
    f.clz_data = $urandom();
    f.mul_hi = $urandom();
    f.mul_lo = $urandom();
    f.div_r = $urandom();
    f.div_q = $urandom();
    f.dmem_data = $urandom();
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    lit("reset_valid", 32'(out.valid), 32'd0);
    lit("reset_all_zero", 32'(out != '0), 32'd0);
    #6 rst_n = 1'b1;

    // Normal capture
    in = rand_fields();
    in.valid = 1; in.rd_wena = 1; in.rd_waddr = 5'd8;
    in.dmem_data = 32'hFFFF_FF80; in.hi_wena = 1; in.hi_data = 32'hA5A5_A5A5;
    step();
    lit("cap_valid", 32'(out.valid), 32'd1);
    lit("cap_rd_wena", 32'(out.rd_wena), 32'd1);
    lit("cap_rd_waddr", 32'(out.rd_waddr), 32'd8);
    lit("cap_dmem", out.dmem_data, 32'hFFFF_FF80);
    lit("cap_hi_wena", 32'(out.hi_wena), 32'd1);
    lit("cap_hi_data", out.hi_data, 32'hA5A5_A5A5);

    // $0 suppression and invalid slot
    in.rd_waddr = 5'd0;
    step();
    lit("r0_rd_wena", 32'(out.rd_wena), 32'd0);
    lit("r0_valid", 32'(out.valid), 32'd1);
    lit("r0_waddr_visible", 32'(out.rd_waddr), 32'd0);
    in.valid = 0; in.rd_waddr = 5'd3;
    step();
    lit("inv_rd_wena", 32'(out.rd_wena), 32'd0);
    lit("inv_hi_wena", 32'(out.hi_wena), 32'd0);

    // Stall hold for 3 edges
    in.valid = 1; in.npc = 32'h0040_0010;
    step();
    lit("stall_pre", out.npc, 32'h0040_0010);
    in.npc = 32'h0040_0014; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      lit("stall_hold", out.npc, 32'h0040_0010);
      lit("stall_hold_valid", 32'(out.valid), 32'd1);
    end
    stall = 0;
    step();
    lit("stall_release", out.npc, 32'h0040_0014);

    // Flush, then flush+stall
    in.lo_wena = 1;
    step();
    lit("pre_flush_lo_wena", 32'(out.lo_wena), 32'd1);
    flush = 1;
    step();
    lit("flush_valid", 32'(out.valid), 32'd0);
    lit("flush_lo_wena", 32'(out.lo_wena), 32'd0);
    flush = 0;
    step();
    lit("refill_valid", 32'(out.valid), 32'd1);
    flush = 1; stall = 1;
    step();
    lit("flush_stall_valid", 32'(out.valid), 32'd0);
    lit("flush_stall_lo_wena", 32'(out.lo_wena), 32'd0);
    flush = 0; stall = 0;

    // Back-to-back
    for (int i = 1; i <= 4; i++) begin
      in.mul_lo = 32'(i);
      step();
      lit("b2b_mul_lo", out.mul_lo, 32'(i));
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in = rand_fields();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      step();
    end
    stall = 0; flush = 0;

    // Reset mid-operation, between edges
    in = rand_fields();
    in.alu_data = 32'h1234_5678; in.valid = 1; in.rd_wena = 1;
    in.rd_waddr = 5'd5;
    step();
    lit("pre_rst_alu", out.alu_data, 32'h1234_5678);
    lit("pre_rst_rd_wena", 32'(out.rd_wena), 32'd1);
    #2 rst_n = 0;
    #1;
    lit("rst_alu", out.alu_data, 32'd0);
    lit("rst_valid", 32'(out.valid), 32'd0);
    lit("rst_rd_wena", 32'(out.rd_wena), 32'd0);
    lit("rst_all_zero", 32'(out != '0), 32'd0);
    step();
    lit("rst_held_valid", 32'(out.valid), 32'd0);
    #2 rst_n = 1;
    step();
    lit("post_rst_alu", out.alu_data, 32'h1234_5678);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
